// File: rtl/i2c_gyro_seq.sv
// Byte-level command sequencer for the I2C gyro: two register writes after reset, then a
// periodic 6-byte auto-increment burst read streamed out on data_out/data_en/data_st.
module i2c_gyro_seq #(
  parameter logic [6:0]  DEV_ADDR  = 7'h69,
  parameter logic [7:0]  OUT_REG   = 8'h28,
  parameter logic [7:0]  INIT0_REG = 8'h20,
  parameter logic [7:0]  INIT0_VAL = 8'h0F,
  parameter logic [7:0]  INIT1_REG = 8'h23,
  parameter logic [7:0]  INIT1_VAL = 8'h30,
  parameter int unsigned POLL_DIV  = 50000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] cmd,
  output logic [7:0] cmd_tx,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  input  logic       cmd_done,
  input  logic [7:0] cmd_rx,
  input  logic       cmd_nack,
  output logic [7:0] data_out,
  output logic       data_en,
  output logic       data_st,
  output logic       init_done,
  output logic [7:0] err_cnt
);

  localparam logic [2:0] CmdStart   = 3'd0;
  localparam logic [2:0] CmdStop    = 3'd1;
  localparam logic [2:0] CmdWrite   = 3'd2;
  localparam logic [2:0] CmdRdAck   = 3'd3;
  localparam logic [2:0] CmdRdNack  = 3'd4;
  localparam logic [2:0] CmdRestart = 3'd5;

  localparam int unsigned   CntW   = $clog2(POLL_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(POLL_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StIStart, StIAddr, StIReg, StIVal, StIStop, StWait, StRStart,
    StRAddrW, StRReg, StRRstart, StRAddrR, StRByte, StRStop, StStrobe, StErrStop
  } state_e;

  state_e          state_q, state_d;
  logic            idx_q, idx_d;
  logic            retry_q, retry_d;
  logic            busy_q, pending_q;
  logic            init_done_q, init_done_d;
  logic            data_en_q, data_en_d;
  logic [2:0]      byte_q, byte_d;
  logic [7:0]      data_out_q, data_out_d;
  logic [7:0]      err_q, err_d;
  logic [CntW-1:0] cnt_q;
  logic            tick, fin, start_rd, is_wr, issue;

  assign tick      = (cnt_q == CntMax);
  // Only a DONE that closes our own outstanding command counts.
  assign fin       = busy_q & cmd_done;
  assign data_out  = data_out_q;
  assign data_en   = data_en_q;
  assign init_done = init_done_q;
  assign err_cnt   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 1'b0;
      retry_q     <= 1'b0;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      data_en_q   <= 1'b0;
      byte_q      <= 3'd0;
      data_out_q  <= 8'd0;
      err_q       <= 8'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      init_done_q <= init_done_d;
      data_en_q   <= data_en_d;
      byte_q      <= byte_d;
      data_out_q  <= data_out_d;
      err_q       <= err_d;
      cnt_q       <= tick ? '0 : cnt_q + 1'b1;
      // Starting a read consumes the request; a tick landing on that edge is dropped.
      if (start_rd) pending_q <= 1'b0;
      else if (tick) pending_q <= 1'b1;
      if (cmd_valid && cmd_ready) busy_q <= 1'b1;
      else if (fin)               busy_q <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    byte_d      = byte_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    data_out_d  = data_out_q;
    data_en_d   = 1'b0;
    start_rd    = 1'b0;
    is_wr       = 1'b0;
    issue       = 1'b0;
    cmd         = CmdStart;
    cmd_tx      = 8'd0;
    data_st     = 1'b0;

    case (state_q)
      StIdle: if (!retry_q || tick) begin
        state_d = StIStart;
        idx_d   = 1'b0;
        retry_d = 1'b0;
      end
      StIStart: begin
        issue = 1'b1;
        if (fin) state_d = StIAddr;
      end
      StIAddr: begin
        issue = 1'b1; is_wr = 1'b1; cmd = CmdWrite; cmd_tx = {DEV_ADDR, 1'b0};
        if (fin) state_d = StIReg;
      end
      StIReg: begin
        issue = 1'b1; is_wr = 1'b1; cmd = CmdWrite; cmd_tx = idx_q ? INIT1_REG : INIT0_REG;
        if (fin) state_d = StIVal;
      end
      StIVal: begin
        issue = 1'b1; is_wr = 1'b1; cmd = CmdWrite; cmd_tx = idx_q ? INIT1_VAL : INIT0_VAL;
        if (fin) state_d = StIStop;
      end
      StIStop: begin
        issue = 1'b1; cmd = CmdStop;
        if (fin && idx_q) begin
          init_done_d = 1'b1;
          state_d     = StWait;
        end else if (fin) begin
          idx_d   = 1'b1;
          state_d = StIStart;
        end
      end
      StWait: if (pending_q) begin
        start_rd = 1'b1;
        state_d  = StRStart;
      end
      StRStart: begin
        issue = 1'b1;
        if (fin) state_d = StRAddrW;
      end
      StRAddrW: begin
        issue = 1'b1; is_wr = 1'b1; cmd = CmdWrite; cmd_tx = {DEV_ADDR, 1'b0};
        if (fin) state_d = StRReg;
      end
      StRReg: begin
        issue = 1'b1; is_wr = 1'b1; cmd = CmdWrite; cmd_tx = OUT_REG | 8'h80;
        if (fin) state_d = StRRstart;
      end
      StRRstart: begin
        issue = 1'b1; cmd = CmdRestart;
        if (fin) state_d = StRAddrR;
      end
      StRAddrR: begin
        issue = 1'b1; is_wr = 1'b1; cmd = CmdWrite; cmd_tx = {DEV_ADDR, 1'b1};
        if (fin) begin
          state_d = StRByte;
          byte_d  = 3'd0;
        end
      end
      StRByte: begin
        issue = 1'b1;
        cmd   = (byte_q == 3'd5) ? CmdRdNack : CmdRdAck;
        if (fin) begin
          data_out_d = cmd_rx;
          data_en_d  = 1'b1;
          if (byte_q == 3'd5) state_d = StRStop;
          else                byte_d  = byte_q + 3'd1;
        end
      end
      StRStop: begin
        issue = 1'b1; cmd = CmdStop;
        if (fin) state_d = StStrobe;
      end
      StStrobe: begin
        data_st = 1'b1;
        state_d = StWait;
      end
      StErrStop: begin
        issue = 1'b1; cmd = CmdStop;
        if (fin && init_done_q) begin
          state_d = StWait;
        end else if (fin) begin
          state_d = StIdle;
          retry_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (is_wr && fin && cmd_nack) begin
      state_d = StErrStop;
      err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    end

    cmd_valid = issue & ~busy_q;
  end

endmodule

// File: tb/tb_i2c_gyro_seq.sv
// Randomized bench for i2c_gyro_seq: a behavioural engine plus a transaction-level
// model of the expected command stream, data bytes, strobes and counters.
module tb_i2c_gyro_seq;

  localparam int unsigned PollDiv = 64;
  localparam logic [2:0] CStart = 3'd0, CStop = 3'd1, CWrite = 3'd2;
  localparam logic [2:0] CRdAck = 3'd3, CRdNack = 3'd4, CRestart = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cmd;
  logic [7:0] cmd_tx;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       cmd_done = 1'b0;
  logic [7:0] cmd_rx = 8'd0;
  logic       cmd_nack = 1'b0;
  logic [7:0] data_out;
  logic       data_en, data_st, init_done;
  logic [7:0] err_cnt;

  i2c_gyro_seq #(.POLL_DIV(PollDiv)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_tx(cmd_tx), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_rx(cmd_rx), .cmd_nack(cmd_nack),
    .data_out(data_out), .data_en(data_en), .data_st(data_st), .init_done(init_done),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] c; logic [7:0] tx; logic fin; } ent_t;
  ent_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc, stall, eng_cnt, frame_bytes, frames, ready_mode, nack_rand;
  bit mp, init_done_m, exp_en, exp_st, wait_tick, aborting, eng_busy, eng_fin, hold_valid;
  bit rx_fixed, nack_armed, spurious;
  logic [7:0] err_m, exp_data, eng_tx, hold_tx, nack_tx;
  logic [2:0] eng_cmd, hold_cmd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic void push(input logic [2:0] c, input logic [7:0] tx, input logic fin);
    ent_t e;
    e.c = c; e.tx = tx; e.fin = fin;
    exp_q.push_back(e);
  endfunction

  function automatic void push_init();
    for (int i = 0; i < 2; i++) begin
      push(CStart, 8'h00, 1'b0);
      push(CWrite, 8'hD2, 1'b0);
      push(CWrite, (i == 1) ? 8'h23 : 8'h20, 1'b0);
      push(CWrite, (i == 1) ? 8'h30 : 8'h0F, 1'b0);
      push(CStop, 8'h00, 1'(i == 1));
    end
  endfunction

  function automatic void push_read();
    push(CStart, 8'h00, 1'b0);
    push(CWrite, 8'hD2, 1'b0);
    push(CWrite, 8'hA8, 1'b0);
    push(CRestart, 8'h00, 1'b0);
    push(CWrite, 8'hD3, 1'b0);
    for (int i = 0; i < 5; i++) push(CRdAck, 8'h00, 1'b0);
    push(CRdNack, 8'h00, 1'b0);
    push(CStop, 8'h00, 1'b1);
  endfunction

  // Engine reaction when the outstanding command completes on the coming edge.
  task automatic finish_cmd();
    bit nk;
    logic [7:0] rx;
    if (eng_cmd == CWrite) begin
      nk = (nack_armed && eng_tx == nack_tx) || ($urandom_range(0, 999) < nack_rand);
      if (nack_armed && eng_tx == nack_tx) nack_armed = 0;
      cmd_nack = nk;
      if (nk) begin
        if (err_m != 8'hFF) err_m++;
        exp_q.delete();
        push(CStop, 8'h00, 1'b0);
        aborting = 1;
      end
    end else if (eng_cmd == CRdAck || eng_cmd == CRdNack) begin
      rx = rx_fixed ? 8'(8'h11 * (frame_bytes + 1)) : 8'($urandom);
      cmd_rx = rx;
      cmd_nack = 1'($urandom);
      exp_en = 1; exp_data = rx;
      frame_bytes++;
    end else begin
      cmd_nack = 1'($urandom);
      if (eng_cmd == CStop) begin
        if (aborting) begin
          aborting = 0;
          if (!init_done_m) wait_tick = 1;
        end else if (eng_fin) begin
          if (init_done_m) begin exp_st = 1; frames++; end
          else init_done_m = 1;
        end
      end
    end
  endtask

  task automatic step();
    bit busy0, rdy, run;
    ent_t e;
    @(negedge clk);
    check_eq("data_en", 32'(data_en), 32'(exp_en));
    if (exp_en && data_en) check_eq("data_out", 32'(data_out), 32'(exp_data));
    check_eq("data_st", 32'(data_st), 32'(exp_st));
    check_eq("init_done", 32'(init_done), 32'(init_done_m));
    check_eq("err_cnt", 32'(err_cnt), 32'(err_m));
    exp_en = 0; exp_st = 0;
    busy0 = eng_busy;
    if (hold_valid)
      check_eq("cmd_hold", 32'({cmd_valid, cmd, cmd_tx}), 32'({1'b1, hold_cmd, hold_tx}));
    hold_valid = 0;
    if (busy0) check_eq("one_outstanding", 32'(cmd_valid), 32'd0);
    if (cmd_valid && !busy0 && exp_q.size() == 0) begin
      if (init_done_m) begin
        check_eq("rd_pending", 32'(mp), 32'd1);
        mp = 0; frame_bytes = 0;
        push_read();
      end else begin
        check_eq("init_wait", 32'(wait_tick), 32'd0);
        push_init();
      end
    end
    run = !busy0 && (exp_q.size() != 0 || (init_done_m && mp) || (!init_done_m && !wait_tick));
    stall = (run && !cmd_valid) ? stall + 1 : 0;
    if (run) begin
      check_eq("stall", 32'(stall > 5), 32'd0);
      if (stall > 5) stall = 0;
    end

    // Effects of the coming rising edge.
    cyc++;
    if (cyc % PollDiv == 0) begin mp = 1; wait_tick = 0; end
    cmd_done = 0; cmd_nack = 0; cmd_rx = 8'($urandom);
    case (ready_mode)
      0:       rdy = 1;
      1:       rdy = ($urandom_range(0, 3) != 0);
      default: rdy = 0;
    endcase
    cmd_ready = rdy;
    if (busy0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        cmd_done = 1; eng_busy = 0;
        finish_cmd();
      end
    end else if (cmd_valid && rdy) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else begin e.c = 3'd7; e.tx = 8'h00; e.fin = 1'b0; end
      check_eq("cmd", 32'({cmd, (cmd == CWrite) ? cmd_tx : 8'h00}),
               32'({e.c, (e.c == CWrite) ? e.tx : 8'h00}));
      eng_busy = 1; eng_cnt = $urandom_range(1, 3);
      eng_cmd = cmd; eng_tx = cmd_tx; eng_fin = e.fin;
    end else if (cmd_valid) begin
      hold_valid = 1; hold_cmd = cmd; hold_tx = cmd_tx;
    end else if (spurious && $urandom_range(0, 9) == 0) begin
      cmd_done = 1; cmd_nack = 1'($urandom);
    end
  endtask

  task automatic do_reset(input int hold);
    #2;
    reset = 1; cmd_done = 0; cmd_nack = 0; cmd_ready = 0;
    #1;
    check_eq("rst_outs", 32'({cmd, cmd_tx, cmd_valid, data_out, data_en, data_st, init_done,
                              err_cnt}), 32'd0);
    repeat (hold) @(negedge clk);
    check_eq("rst_hold", 32'({cmd, cmd_tx, cmd_valid, data_out, data_en, data_st, init_done,
                              err_cnt}), 32'd0);
    reset = 0;
    exp_q.delete();
    mp = 0; init_done_m = 0; err_m = 8'd0; exp_en = 0; exp_st = 0; wait_tick = 0;
    aborting = 0; eng_busy = 0; hold_valid = 0; stall = 0; frame_bytes = 0;
    nack_armed = 0;
    cyc = 1;
  endtask

  initial begin
    int f;
    ready_mode = 0; rx_fixed = 0; nack_rand = 0; spurious = 0; frames = 0;
    do_reset(3);

    // Init stream after reset release.
    for (int i = 0; i < 400 && !init_done_m; i++) step();
    check_eq("t1_init", 32'(init_done_m), 32'd1);
    check_eq("t1_err", 32'(err_cnt), 32'd0);

    // First read frame with known bytes.
    rx_fixed = 1; f = frames;
    for (int i = 0; i < 400 && frames == f; i++) step();
    check_eq("t2_frame", 32'(frames - f), 32'd1);
    rx_fixed = 0;

    // NACK on the read address, then a full frame on a later tick.
    nack_armed = 1; nack_tx = 8'hD3; f = frames;
    for (int i = 0; i < 600 && frames == f; i++) step();
    check_eq("t3_frame", 32'(frames - f), 32'd1);
    check_eq("t3_nack", 32'(nack_armed), 32'd0);
    check_eq("t3_err", 32'(err_cnt), 32'd1);

    // NACK on the first init register write.
    do_reset(2);
    nack_armed = 1; nack_tx = 8'h20;
    for (int i = 0; i < 600 && !init_done_m; i++) step();
    check_eq("t4_init", 32'(init_done_m), 32'd1);
    check_eq("t4_err", 32'(err_cnt), 32'd1);

    // Engine stalls mid-read for 200 cycles; pending stays one-deep.
    f = frames;
    for (int i = 0; i < 400 && frames == f; i++) step();
    for (int i = 0; i < 400 && exp_q.size() == 0; i++) step();
    ready_mode = 2;
    repeat (200) step();
    ready_mode = 0;
    repeat (300) step();

    // Reset in the middle of the byte phase.
    for (int i = 0; i < 600 && !(frame_bytes == 3 && exp_q.size() != 0 && init_done_m); i++)
      step();
    check_eq("t6_mid", 32'(frame_bytes), 32'd3);
    step();
    do_reset(2);
    f = frames;
    for (int i = 0; i < 800 && frames == f; i++) step();
    check_eq("t6_frame", 32'(frames - f), 32'd1);

    // Random engine behaviour with a reset in between.
    ready_mode = 1; nack_rand = 30; spurious = 1;
    repeat (1500) step();
    do_reset($urandom_range(1, 4));
    repeat (1500) step();
    ready_mode = 0; nack_rand = 0; spurious = 0;
    f = frames;
    for (int i = 0; i < 800 && frames == f; i++) step();
    check_eq("final_frame", 32'(frames - f), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_gyro_seq.md
Name: i2c_gyro_seq

Overview:
Transaction sequencer for the I2C gyro path.
- Issues byte-level commands to an I2C bit engine.
- After reset, configures the gyro with two register writes.
- Then performs a 6-byte auto-increment burst read every POLL_DIV clocks.
- Emits each received byte on DATA_OUT/DATA_EN and a frame strobe DATA_ST, so the existing gyro shift/latch registers in the I2C block can consume them.

Parameters:
DEV_ADDR, 7'h69, 7-bit gyro slave address
OUT_REG, 8'h28, first output register; sent as OUT_REG|8'h80 (auto-increment)
INIT0_REG, 8'h20, first init register address
INIT0_VAL, 8'h0F, first init value
INIT1_REG, 8'h23, second init register address
INIT1_VAL, 8'h30, second init value
POLL_DIV, 50000, clocks between read triggers (>=2)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous active-high reset
CMD  out  3  engine command: 0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 RESTART
CMD_TX  out  8  byte to send with WRITE
CMD_VALID  out  1  command valid; held until accepted
CMD_READY  in  1  engine accepts when CMD_VALID&CMD_READY
CMD_DONE  in  1  one-cycle pulse; command finished
CMD_RX  in  8  received byte; valid with CMD_DONE after READ_*
CMD_NACK  in  1  slave NACKed; valid with CMD_DONE after WRITE
DATA_OUT  out  8  received data byte
DATA_EN  out  1  one-cycle pulse; DATA_OUT valid
DATA_ST  out  1  one-cycle frame-complete strobe
INIT_DONE  out  1  init writes acknowledged
ERR_CNT  out  8  saturating NACK error counter

Behaviour:
Reset values
- While RESET is high, all outputs are 0 and the state is IDLE.
- Poll counter is 0 and the pending flag is cleared.
- Reset is asynchronous and may occur mid-transaction. The sequencer does not issue STOP; the engine is reset by the same RESET.

Command handshake
- At most one command is outstanding.
- CMD, CMD_TX and CMD_VALID are stable until the accept cycle.
- CMD_VALID drops the cycle after accept.
- The sequencer waits for CMD_DONE before the next command. CMD_DONE with no outstanding command is ignored.

Poll timer
- Free-running counter 0..POLL_DIV-1; it raises tick on wrap and runs from reset.
- tick sets pending; pending is cleared when a read transaction starts.
- A tick while pending is already set is dropped (one-deep).

Init sequence (from IDLE, one cycle after reset release)
- START; WRITE {DEV_ADDR,0}; WRITE INIT0_REG; WRITE INIT0_VAL; STOP.
- Then the same sequence for INIT1.
- INIT_DONE is set after the second STOP completes and stays set until reset.

Read sequence (state WAIT, INIT_DONE=1, pending=1)
- START; WRITE {DEV_ADDR,0}; WRITE OUT_REG|8'h80; RESTART; WRITE {DEV_ADDR,1}.
- READ_ACK x5, then READ_NACK x1, then STOP.
- On each READ CMD_DONE, in the same cycle:
  - DATA_OUT<=CMD_RX
  - DATA_EN=1 for 1 cycle
  - Bytes go out in bus order X_L,X_H,Y_L,Y_H,Z_L,Z_H.
- One cycle after STOP's CMD_DONE: DATA_ST=1 for 1 cycle.
- DATA_ST never coincides with DATA_EN.
- Byte counter is 3 bits, 0..5.

Errors
- CMD_NACK=1 on any WRITE's CMD_DONE aborts: go to ERR_STOP, issue STOP, ERR_CNT+=1 (saturates at 255).
- No DATA_ST is issued for an aborted frame; any DATA_EN already issued stands.
- Init abort returns to IDLE and retries init on the next tick. Read abort returns to WAIT.

States
IDLE, I_START, I_ADDR, I_REG, I_VAL, I_STOP, WAIT, R_START, R_ADDRW, R_REG, R_RSTART, R_ADDRR, R_BYTE, R_STOP, STROBE, ERR_STOP.
- I_* states carry a 1-bit init index.

Test Plan:
1. Reset release, engine always ready with DONE 2 cycles after accept, no NACKs -> command stream START, WR D2, WR 20, WR 0F, STOP, START, WR D2, WR 23, WR 30, STOP. INIT_DONE=1 after the second STOP. ERR_CNT=0.
2. POLL_DIV=64, engine returns RX 11,22,33,44,55,66 -> stream START, WR D2, WR A8, RESTART, WR D3, RD_ACK x5, RD_NACK, STOP. Six DATA_EN pulses with those bytes in order. Exactly one DATA_ST, one cycle after STOP DONE.
3. NACK on WR D3 of a read -> STOP issued, ERR_CNT=1, no further DATA_EN, no DATA_ST. The next tick yields a complete frame.
4. NACK on WR 20 during init -> STOP, ERR_CNT=1, INIT_DONE=0. Init restarts at the next tick and completes.
5. CMD_READY held low for 200 cycles with POLL_DIV=64 -> CMD/CMD_TX/CMD_VALID stable throughout. Only one extra read follows (pending is one-deep).
6. RESET asserted during R_BYTE after 3 bytes -> all outputs 0 immediately (asynchronous). After release, the init sequence replays; no DATA_ST appears before the first full frame.
